fpmul_arbiter: RTL

- Round-robin controller that shares one FPMUL (Start/Done handshake, 32-bit A/B in, P plus OF/UF/NaNF/InfF/DNF/ZF out) among N requesters.
- Captures the winning requester's operands and pulses Start to the multiplier.
- Waits for Done, then returns the product and flags to that requester.
- Guards against a hung multiplier with a timeout.

---
 rtl/fpmul_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fpmul_arbiter.sv
// Round-robin share of one Start/Done FPMUL among N requesters; Req-to-Gnt 1 cycle, Gnt-to-RspValid = Done latency + 1.
// No queuing: one transaction in flight, requesters hold Req until Gnt; a hung multiplier is aborted after TIMEOUT WAIT cycles.
module fpmul_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic [N-1:0]   Req,
    input  logic [N*W-1:0] ReqA,
    input  logic [N*W-1:0] ReqB,
    output logic [N-1:0]   Gnt,
    output logic [N-1:0]   RspValid,
    output logic [W-1:0]   RspP,
    output logic [5:0]     RspFlags,
    output logic           RspErr,
    output logic           Busy,
    output logic           MulStart,
    output logic [W-1:0]   MulA,
    output logic [W-1:0]   MulB,
    input  logic           MulDone,
    input  logic [W-1:0]   MulP,
    input  logic [5:0]     MulFlags
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         r_state, w_state;
    logic [IW-1:0]  r_owner, w_owner;
    logic [IW-1:0]  r_last, w_last;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [N-1:0]   r_gnt, w_gnt;
    logic [N-1:0]   r_rsp_vld, w_rsp_vld;
    logic [W-1:0]   r_rsp_p, w_rsp_p;
    logic [5:0]     r_rsp_flags, w_rsp_flags;
    logic           r_rsp_err, w_rsp_err;
    logic           r_busy, w_busy;
    logic           r_mul_start, w_mul_start;
    logic [W-1:0]   r_mul_a, w_mul_a;
    logic [W-1:0]   r_mul_b, w_mul_b;

    logic [IW-1:0]  w_pick;
    logic           w_found;
    logic [IW:0]    w_sum;

    // Scan from the slot after the last winner, wrapping, so the last winner is checked last.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            if (!w_found && Req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_owner     = r_owner;
        w_last      = r_last;
        w_cnt       = r_cnt;
        w_gnt       = '0;
        w_rsp_vld   = '0;
        w_mul_start = 1'b0;
        w_rsp_p     = r_rsp_p;
        w_rsp_flags = r_rsp_flags;
        w_rsp_err   = r_rsp_err;
        w_busy      = r_busy;
        w_mul_a     = r_mul_a;
        w_mul_b     = r_mul_b;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_owner     = w_pick;
                    w_mul_a     = ReqA[int'(w_pick)*W +: W];
                    w_mul_b     = ReqB[int'(w_pick)*W +: W];
                    w_gnt       = N'(1) << w_pick;
                    w_mul_start = 1'b1;
                    w_busy      = 1'b1;
                    w_state     = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt   = '0;
                w_state = WAIT;
            end
            WAIT: begin
                // Done wins over a timeout landing on the same edge.
                if (MulDone) begin
                    w_rsp_p     = MulP;
                    w_rsp_flags = MulFlags;
                    w_rsp_err   = 1'b0;
                    w_rsp_vld   = N'(1) << r_owner;
                    w_state     = RESP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_rsp_p     = '0;
                    w_rsp_flags = '0;
                    w_rsp_err   = 1'b1;
                    w_rsp_vld   = N'(1) << r_owner;
                    w_state     = RESP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            RESP: begin
                w_last  = r_owner;
                w_busy  = 1'b0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_last      <= IW'(N - 1);
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_vld   <= '0;
            r_rsp_p     <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_state     <= w_state;
            r_owner     <= w_owner;
            r_last      <= w_last;
            r_cnt       <= w_cnt;
            r_gnt       <= w_gnt;
            r_rsp_vld   <= w_rsp_vld;
            r_rsp_p     <= w_rsp_p;
            r_rsp_flags <= w_rsp_flags;
            r_rsp_err   <= w_rsp_err;
            r_busy      <= w_busy;
            r_mul_start <= w_mul_start;
            r_mul_a     <= w_mul_a;
            r_mul_b     <= w_mul_b;
        end
    end

    assign Gnt      = r_gnt;
    assign RspValid = r_rsp_vld;
    assign RspP     = r_rsp_p;
    assign RspFlags = r_rsp_flags;
    assign RspErr   = r_rsp_err;
    assign Busy     = r_busy;
    assign MulStart = r_mul_start;
    assign MulA     = r_mul_a;
    assign MulB     = r_mul_b;

endmodule
